// File: rtl/fp16_mul_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_mul_arb_pkg
//  Description : Shared types and the round-robin picker for FP unit arbiters.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp16_mul_arb_pkg;

    localparam int FP16_W    = 16;
    localparam int c_max_req = 8;

    typedef logic [FP16_W-1:0] fp16_t;

    // One-hot grant of the first eligible requester after 'last', wrapping modulo n.
    function automatic logic [c_max_req-1:0] rr_pick(
        input logic [c_max_req-1:0] eligible,
        input logic [2:0]           last,
        input int                   n
    );
        logic [c_max_req-1:0] grant;
        logic [2:0]           idx;
        grant = '0;
        for (int k = 1; k <= c_max_req; k++) begin
            idx = 3'((int'(last) + k) % n);
            if (k <= n && grant == '0 && eligible[idx]) grant[idx] = 1'b1;
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_fp16_singlecycle.sv
`default_nettype none
// ============================================================================
//  Module      : mul_fp16_singlecycle
//  Description : FP16 multiplier, result and done registered one cycle after
//                start. Round-to-nearest-even; subnormals flush to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_fp16_singlecycle (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [15:0] result
);

    logic        w_sign, w_guard, w_sticky, w_round;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [21:0] w_prod;
    logic [9:0]  w_mant;
    logic [10:0] w_mant_r;
    logic [6:0]  w_exp;
    logic [4:0]  w_res_exp;
    logic [15:0] w_result;

    always_comb begin
        w_sign   = a[15] ^ b[15];
        w_a_nan  = (&a[14:10]) & (|a[9:0]);
        w_b_nan  = (&b[14:10]) & (|b[9:0]);
        w_a_inf  = (&a[14:10]) & ~(|a[9:0]);
        w_b_inf  = (&b[14:10]) & ~(|b[9:0]);
        w_a_zero = ~(|a[14:10]);
        w_b_zero = ~(|b[14:10]);
        w_prod   = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        if (w_prod[21]) begin
            w_mant   = w_prod[20:11];
            w_guard  = w_prod[10];
            w_sticky = |w_prod[9:0];
        end else begin
            w_mant   = w_prod[19:10];
            w_guard  = w_prod[9];
            w_sticky = |w_prod[8:0];
        end
        w_round   = w_guard & (w_sticky | w_mant[0]);
        w_mant_r  = {1'b0, w_mant} + {10'd0, w_round};
        // Biased exponent sum still carrying the extra bias of 15.
        w_exp     = {2'b00, a[14:10]} + {2'b00, b[14:10]} + {6'd0, w_prod[21]} + {6'd0, w_mant_r[10]};
        w_res_exp = w_exp[4:0] - 5'd15;

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_result = 16'h7E00;
        else if (w_a_inf || w_b_inf)
            w_result = {w_sign, 5'h1F, 10'd0};
        else if (w_a_zero || w_b_zero || w_exp <= 7'd15)
            w_result = {w_sign, 15'd0};
        else if (w_exp >= 7'd46)
            w_result = {w_sign, 5'h1F, 10'd0};
        else
            w_result = {w_sign, w_res_exp, w_mant_r[9:0]};
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            done   <= 1'b0;
            result <= 16'd0;
        end else begin
            done   <= start;
            result <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_mul_arbiter
//  Description : Round-robin sharing of one FP16 multiplier among NREQ
//                requesters, each with a one-entry response buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp16_mul_arbiter
    import fp16_mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*FP16_W-1:0] req_a,
    input  logic [NREQ*FP16_W-1:0] req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [NREQ*FP16_W-1:0] rsp_result,
    output logic                   busy
);

    localparam logic [IDW-1:0] c_last_rst = IDW'(NREQ - 1);

    logic                   r_inflight_v;
    logic [IDW-1:0]         r_inflight_id;
    logic [IDW-1:0]         r_last_grant;
    logic [NREQ-1:0]        r_rsp_valid;
    logic [NREQ*FP16_W-1:0] r_rsp_result;

    logic [NREQ-1:0]        w_elig;
    logic [NREQ-1:0]        w_grant;
    logic                   w_fire;
    logic [IDW-1:0]         w_gid;
    fp16_t                  w_op_a, w_op_b, w_mul_result;
    logic                   w_mul_done;

    // A slot whose buffer is draining this cycle is free by the capture edge.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++)
            w_elig[i] = req_valid[i] & ~RST
                      & ~(r_inflight_v && r_inflight_id == IDW'(i))
                      & (~r_rsp_valid[i] | rsp_ready[i]);
    end

    assign w_grant = NREQ'(rr_pick(c_max_req'(w_elig), 3'(r_last_grant), NREQ));
    assign w_fire  = |w_grant;

    always_comb begin
        w_gid = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_grant[i]) w_gid = IDW'(i);
    end

    assign w_op_a = req_a[w_gid*FP16_W +: FP16_W];
    assign w_op_b = req_b[w_gid*FP16_W +: FP16_W];

    mul_fp16_singlecycle u_mul (
        .clk    (clk),
        .nRST   (~RST),
        .start  (w_fire),
        .a      (w_op_a),
        .b      (w_op_b),
        .done   (w_mul_done),
        .result (w_mul_result)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_inflight_v  <= 1'b0;
            r_inflight_id <= '0;
            r_last_grant  <= c_last_rst;
        end else begin
            r_inflight_v <= w_fire;
            if (w_fire) begin
                r_inflight_id <= w_gid;
                r_last_grant  <= w_gid;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_mul_done && r_inflight_id == IDW'(i)) begin
                    r_rsp_valid[i]                     <= 1'b1;
                    r_rsp_result[i*FP16_W +: FP16_W]   <= w_mul_result;
                end else if (rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = w_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign busy       = r_inflight_v | (|r_rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_fp16_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_mul_arbiter
//  Description : Scoreboard bench for the FP16 multiplier arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_mul_arbiter;

    localparam int NREQ = 4;
    localparam int NV   = 11;

    // Operand pairs with hand-computed FP16 products.
    localparam logic [15:0] VA [NV] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h0000, 16'h3C00, 16'h4200,
                                        16'h3800, 16'hBC00, 16'h7C00, 16'h3C01, 16'h7BFF};
    localparam logic [15:0] VB [NV] = '{16'h4000, 16'h3E00, 16'h4200, 16'h3C00, 16'h3C00, 16'h4200,
                                        16'h3800, 16'h3C00, 16'h4000, 16'h3C01, 16'h4000};
    localparam logic [15:0] VP [NV] = '{16'h4000, 16'h4080, 16'hC600, 16'h0000, 16'h3C00, 16'h4880,
                                        16'h3400, 16'hBC00, 16'h7C00, 16'h3C02, 16'h7C00};

    typedef struct {
        int          cyc;
        logic [15:0] res;
    } sb_t;

    logic                 clk = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      req_valid, rsp_ready;
    logic [NREQ*16-1:0]   req_a, req_b;
    wire  [NREQ-1:0]      req_ready, rsp_valid;
    wire  [NREQ*16-1:0]   rsp_result;
    wire                  busy;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  gcnt [NREQ];
    sb_t sb [NREQ][$];
    sb_t ent;
    logic [16:0] lk;

    fp16_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] lookup(input logic [15:0] a, input logic [15:0] b);
        for (int v = 0; v < NV; v++)
            if (VA[v] == a && VB[v] == b) return {1'b1, VP[v]};
        return 17'd0;
    endfunction

    task automatic set_op(input int i, input int v);
        req_a[16*i +: 16] = VA[v];
        req_b[16*i +: 16] = VB[v];
    endtask

    task automatic do_reset;
        RST       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
    endtask

    // Scoreboard: push on transfer, check at transfer+2, pop on drain.
    always @(negedge clk) begin
        if (RST) begin
            for (int i = 0; i < NREQ; i++) sb[i].delete();
        end else begin
            total++;
            if (dut.w_mul_done !== dut.r_inflight_v) begin
                bad++;
                $display("FAIL done_vs_inflight cyc=%0d got done=%b want %b", cyc, dut.w_mul_done, dut.r_inflight_v);
            end
            total++;
            if ((req_ready & (req_ready - 4'd1)) !== 4'd0) begin
                bad++;
                $display("FAIL ready_onehot cyc=%0d got %b want at most one bit", cyc, req_ready);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (sb[i].size() > 0 && sb[i][0].cyc + 2 == cyc) begin
                    total++;
                    if (rsp_valid[i] !== 1'b1 || rsp_result[16*i +: 16] !== sb[i][0].res) begin
                        bad++;
                        $display("FAIL rsp[%0d] cyc=%0d got valid=%b res=%h want valid=1 res=%h",
                                 i, cyc, rsp_valid[i], rsp_result[16*i +: 16], sb[i][0].res);
                    end
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected[%0d] cyc=%0d got res=%h want no response", i, cyc, rsp_result[16*i +: 16]);
                    end else begin
                        void'(sb[i].pop_front());
                    end
                end
                if (req_valid[i] && req_ready[i]) begin
                    gcnt[i]++;
                    lk = lookup(req_a[16*i +: 16], req_b[16*i +: 16]);
                    ent.cyc = cyc;
                    ent.res = lk[15:0];
                    sb[i].push_back(ent);
                end
            end
        end
    end

    task automatic test_reset;
        RST       = 1'b1;
        req_valid = '1;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        @(posedge clk);
        #3;
        total++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_result !== 64'd0) begin
            bad++;
            $display("FAIL reset_state got ready=%b rsp_valid=%b busy=%b res=%h want all zero",
                     req_ready, rsp_valid, busy, rsp_result);
        end
    endtask

    task automatic test_single;
        do_reset();
        set_op(0, 0);
        req_valid = 4'b0001;
        #2;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_grant got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        #2;
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_t1 got rsp_valid=%b busy=%b want 0000 1", rsp_valid, busy);
        end
        @(posedge clk);
        #3;
        total++;
        if (rsp_valid !== 4'b0001 || rsp_result[15:0] !== 16'h4000) begin
            bad++;
            $display("FAIL single_t2 got valid=%b res=%h want 0001 4000", rsp_valid, rsp_result[15:0]);
        end
        @(posedge clk);
        #1 rsp_ready = 4'b0001;
        @(posedge clk);
        #3;
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_result[15:0] !== 16'h4000) begin
            bad++;
            $display("FAIL single_drain got valid=%b busy=%b res=%h want 0000 0 4000", rsp_valid, busy, rsp_result[15:0]);
        end
    endtask

    task automatic test_all_four;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1);
        req_valid = '1;
        rsp_ready = '1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            #2;
            total++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                bad++;
                $display("FAIL all4_order k=%0d got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_backpressure;
        int  g0, g2;
        bit  prev0, hit;
        do_reset();
        set_op(0, 1);
        set_op(1, 2);
        set_op(2, 5);
        req_valid = 4'b0111;
        rsp_ready = 4'b0101;
        g0 = 0;
        g2 = 0;
        prev0 = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            #2;
            if (c >= 2) begin
                total++;
                if (req_ready[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_blocked c=%0d got ready1=%b want 0", c, req_ready[1]);
                end
                if (req_ready[0]) g0++;
                if (req_ready[2]) g2++;
            end
            prev0 = req_ready[0];
        end
        total++;
        if (g0 < 5 || g2 < 5) begin
            bad++;
            $display("FAIL bp_others got g0=%0d g2=%0d want both >= 5", g0, g2);
        end
        hit = 1'b0;
        for (int c = 0; c < 4 && !hit; c++) begin
            @(posedge clk);
            if (prev0) begin
                #1 rsp_ready = 4'b0111;
                #2;
                hit = 1'b1;
                total++;
                if (req_ready !== 4'b0010) begin
                    bad++;
                    $display("FAIL bp_release got %b want 0010", req_ready);
                end
            end else begin
                #3 prev0 = req_ready[0];
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL bp_release_timeout got no grant to 0 want one within 4 cycles");
        end
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back;
        int bv [4] = '{5, 6, 9, 10};
        int k, last;
        do_reset();
        rsp_ready = 4'b0001;
        k = 0;
        last = -1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            set_op(0, bv[k]);
            req_valid = 4'b0001;
            #2;
            if (req_ready[0]) begin
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 2) begin
                        bad++;
                        $display("FAIL b2b_spacing got %0d want 2", cyc - last);
                    end
                end
                last = cyc;
                k++;
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        total++;
        if (k != 4) begin
            bad++;
            $display("FAIL b2b_count got %0d want 4", k);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset_midflight;
        do_reset();
        set_op(1, 5);
        req_valid = 4'b0010;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #3;
        total++;
        if (rsp_valid !== 4'b0010 || rsp_result[31:16] !== 16'h4880) begin
            bad++;
            $display("FAIL rmf_setup got valid=%b res=%h want 0010 4880", rsp_valid, rsp_result[31:16]);
        end
        @(posedge clk);
        #1;
        set_op(0, 0);
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = '0;
        RST = 1'b1;
        #2;
        total++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_result !== 64'd0 || dut.w_mul_done !== 1'b0) begin
            bad++;
            $display("FAIL rmf_cleared got valid=%b busy=%b res=%h done=%b want all zero",
                     rsp_valid, busy, rsp_result, dut.w_mul_done);
        end
        @(posedge clk);
        #3;
        total++;
        if (rsp_valid !== 4'b0000 || rsp_result !== 64'd0) begin
            bad++;
            $display("FAIL rmf_suppressed got valid=%b res=%h want zero", rsp_valid, rsp_result);
        end
        @(posedge clk);
        #1;
        set_op(1, 5);
        req_valid = 4'b0011;
        RST = 1'b0;
        #2;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rmf_first_grant got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_fairness;
        int d;
        do_reset();
        set_op(2, 7);
        set_op(3, 8);
        rsp_ready = '1;
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        req_valid = 4'b1100;
        repeat (100) @(posedge clk);
        #1 req_valid = '0;
        d = gcnt[2] - gcnt[3];
        total++;
        if (d > 1 || d < -1) begin
            bad++;
            $display("FAIL fair_balance got g2=%0d g3=%0d want diff <= 1", gcnt[2], gcnt[3]);
        end
        total++;
        if (gcnt[2] + gcnt[3] < 98) begin
            bad++;
            $display("FAIL fair_throughput got %0d want >= 98", gcnt[2] + gcnt[3]);
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
